// File: rtl/dram_app_responder.sv
// dram_app_responder: on-chip stand-in for the DRAM controller app interface.
// Define DRAM_RESP_THROTTLE_EN to force periodic backpressure on app_rdy/app_wdf_rdy.
module dram_app_responder #(
    parameter int ADDR_WIDTH      = 27,
    parameter int APP_DATA_WIDTH  = 256,
    parameter int DEPTH_LOG2      = 10,
    parameter int RD_LATENCY      = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      dram_clk,
    input  logic                      reset,
    input  logic                      app_en,
    input  logic                      dram_read,
    input  logic [ADDR_WIDTH-1:0]     app_addr,
    output logic                      app_rdy,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_rdy,
    output logic                      app_rd_data_valid,
    output logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      error
);
    localparam int W     = APP_DATA_WIDTH;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PL    = RD_LATENCY - 1;
    localparam int FW    = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_B0, S_B1} state_t;

    logic [2*W-1:0]        mem [DEPTH];
    logic [2*W-1:0]        pd [PL];
    logic [2*W-1:0]        fq [MAX_OUTSTANDING];
    logic [PL-1:0]         pv;
    logic [FW-1:0]         wp, rp;
    logic [CW-1:0]         cnt, outstanding;
    logic [DEPTH_LOG2-1:0] idx, wcmd_idx;
    logic [W-1:0]          wb0, wb1;
    logic                  reset_d, wcmd_full, wdata_full, have_b0, throttled;
    logic                  cmd_acc, rd_acc, wr_acc, beat_acc, beat_bad, commit, push, pop, avail;
    logic                  unused_addr;
    state_t                state, state_nx;

`ifdef DRAM_RESP_THROTTLE_EN
    logic [4:0] thr;
    always_ff @(posedge dram_clk)
        thr <= reset ? 5'd0 : thr + 5'd1;
    assign throttled = &thr[4:2];
`else
    assign throttled = 1'b0;
`endif

    function automatic logic [FW-1:0] inc(input logic [FW-1:0] p);
        return p == FW'(MAX_OUTSTANDING - 1) ? '0 : p + FW'(1);
    endfunction

    assign idx         = app_addr[3+:DEPTH_LOG2];
    assign unused_addr = ^app_addr[ADDR_WIDTH-1:3+DEPTH_LOG2];
    assign app_rdy     = !reset_d && !wcmd_full && (outstanding < CW'(MAX_OUTSTANDING)) && !throttled;
    assign app_wdf_rdy = !wdata_full && !throttled;
    assign cmd_acc     = app_en && app_rdy;
    assign rd_acc      = cmd_acc && dram_read;
    assign wr_acc      = cmd_acc && !dram_read;
    assign beat_acc    = app_wdf_wren && app_wdf_rdy;
    assign beat_bad    = beat_acc && (app_wdf_end != have_b0);
    assign commit      = wcmd_full && wdata_full;
    assign push        = pv[PL-1];
    assign pop         = state == S_B1;

    // Bypass lets a burst leaving the pipeline start its beat0 without an extra FIFO cycle
    always_comb begin
        avail    = push || (cnt > CW'(pop));
        state_nx = state == S_B0 ? S_B1 : (avail ? S_B0 : S_IDLE);
    end

    always_ff @(posedge dram_clk) begin
        if (reset) begin
            reset_d     <= 1'b1;
            wcmd_full   <= 1'b0;
            wdata_full  <= 1'b0;
            have_b0     <= 1'b0;
            outstanding <= '0;
            pv          <= '0;
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            state       <= S_IDLE;
            error       <= 1'b0;
        end else begin
            reset_d <= 1'b0;
            if (wr_acc) begin
                wcmd_full <= 1'b1;
                wcmd_idx  <= idx;
            end else if (commit) begin
                wcmd_full <= 1'b0;
            end
            if (commit)
                wdata_full <= 1'b0;
            else if (beat_acc && !beat_bad && have_b0)
                wdata_full <= 1'b1;
            if (beat_acc && !beat_bad)
                have_b0 <= !have_b0;
            outstanding <= outstanding + CW'(rd_acc) - CW'(pop);
            pv          <= (pv << 1) | PL'(rd_acc);
            if (push)
                wp <= inc(wp);
            if (pop)
                rp <= inc(rp);
            cnt   <= cnt + CW'(push) - CW'(pop);
            state <= state_nx;
            error <= error || beat_bad || (cmd_acc && |app_addr[2:0])
                     || (push && !pop && cnt == CW'(MAX_OUTSTANDING));
        end
    end

    // Storage paths carry no reset; the array must survive reset
    always_ff @(posedge dram_clk) begin
        if (!reset && commit)
            mem[wcmd_idx] <= {wb1, wb0};
        if (beat_acc && !beat_bad && !have_b0)
            wb0 <= app_wdf_data;
        if (beat_acc && !beat_bad && have_b0)
            wb1 <= app_wdf_data;
        pd[0] <= mem[idx];
        for (int i = PL - 1; i > 0; i--)
            pd[i] <= pd[i-1];
        if (push)
            fq[wp] <= pd[PL-1];
    end

    assign app_rd_data_valid = state != S_IDLE;
    assign app_rd_data       = state == S_B0 ? fq[rp][0+:W] : (state == S_B1 ? fq[rp][W+:W] : '0);
endmodule

// File: tb/tb_dram_app_responder.sv
// tb_dram_app_responder: directed checks of write ordering, read latency, streaming, wrap, errors and reset.
module tb_dram_app_responder;
    localparam int W = 256;

    logic          dram_clk = 1'b0, reset = 1'b1, app_en = 1'b0, dram_read = 1'b0;
    logic          app_wdf_wren = 1'b0, app_wdf_end = 1'b0;
    logic [26:0]   app_addr = '0;
    logic [W-1:0]  app_wdf_data = '0;
    logic          app_rdy, app_wdf_rdy, app_rd_data_valid, error;
    logic [W-1:0]  app_rd_data;
    int            vectors = 0, miscompares = 0;

    localparam logic [W-1:0] PA = {64{4'hA}}, PB = {64{4'hB}}, PC = {64{4'hC}}, PD = {64{4'hD}};
    localparam logic [W-1:0] PE = {64{4'hE}}, PF = {64{4'hF}}, PG = {64{4'h6}}, PH = {64{4'h9}};

    always #5 dram_clk = ~dram_clk;

    dram_app_responder dut (
        .dram_clk(dram_clk), .reset(reset), .app_en(app_en), .dram_read(dram_read),
        .app_addr(app_addr), .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data), .error(error)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge dram_clk);
    endtask

    task automatic wait_rdy(input string what);
        int n = 0;
        while (!app_rdy && n < 50) begin cyc(); n++; end
        if (!app_rdy) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout app_rdy got %0b want 1", what, app_rdy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic write_burst(input logic [26:0] a, input logic [W-1:0] b0, input logic [W-1:0] b1);
        wait_rdy("wr_cmd");
        app_en = 1'b1; dram_read = 1'b0; app_addr = a; cyc();
        app_en = 1'b0; app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = b0; cyc();
        app_wdf_end = 1'b1; app_wdf_data = b1; cyc();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0; cyc();
        cyc();
    endtask

    task automatic read_burst(input logic [26:0] a, output int lat, output logic [W-1:0] d0,
                              output logic [W-1:0] d1, output logic v1);
        wait_rdy("rd_cmd");
        app_en = 1'b1; dram_read = 1'b1; app_addr = a; cyc();
        app_en = 1'b0; lat = 1;
        while (!app_rd_data_valid && lat < 40) begin cyc(); lat++; end
        d0 = app_rd_data; cyc();
        v1 = app_rd_data_valid; d1 = app_rd_data; cyc();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (app_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_app_rdy got %0b want 0", app_rdy); end
        vectors++; if (app_wdf_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_wdf_rdy got %0b want 1", app_wdf_rdy); end
        vectors++; if (app_rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", app_rd_data_valid); end
        vectors++; if (app_rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", app_rd_data); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %0b want 0", error); end
        cyc();
        vectors++; if (app_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_app_rdy_after got %0b want 1", app_rdy); end
    endtask

    task automatic test_cmd_first();
        int lat; logic [W-1:0] d0, d1; logic v1;
        write_burst(27'h10, PA, PB);
        read_burst(27'h10, lat, d0, d1, v1);
        vectors++; if (lat != 8) begin miscompares++; $display("FAIL cmd_first_latency got %0d want 8", lat); end
        vectors++; if (d0 !== PA) begin miscompares++; $display("FAIL cmd_first_beat0 got %h want %h", d0, PA); end
        vectors++; if (v1 !== 1'b1) begin miscompares++; $display("FAIL cmd_first_beat1_valid got %0b want 1", v1); end
        vectors++; if (d1 !== PB) begin miscompares++; $display("FAIL cmd_first_beat1 got %h want %h", d1, PB); end
        vectors++; if (app_rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL cmd_first_after got %0b want 0", app_rd_data_valid); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL cmd_first_error got %0b want 0", error); end
    endtask

    task automatic test_data_first();
        int lat; logic [W-1:0] d0, d1; logic v1;
        vectors++; if (app_wdf_rdy !== 1'b1) begin miscompares++; $display("FAIL data_first_rdy_pre got %0b want 1", app_wdf_rdy); end
        app_wdf_wren = 1'b1; app_wdf_end = 1'b0; app_wdf_data = PC; cyc();
        app_wdf_end = 1'b1; app_wdf_data = PD; cyc();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (app_wdf_rdy !== 1'b0) begin miscompares++; $display("FAIL data_first_hold%0d got %0b want 0", i, app_wdf_rdy); end
            cyc();
        end
        vectors++; if (app_rdy !== 1'b1) begin miscompares++; $display("FAIL data_first_cmd_rdy got %0b want 1", app_rdy); end
        app_en = 1'b1; dram_read = 1'b0; app_addr = 27'h18; cyc();
        app_en = 1'b0;
        vectors++; if (app_wdf_rdy !== 1'b0) begin miscompares++; $display("FAIL data_first_commit_wdf got %0b want 0", app_wdf_rdy); end
        vectors++; if (app_rdy !== 1'b0) begin miscompares++; $display("FAIL data_first_commit_rdy got %0b want 0", app_rdy); end
        cyc();
        vectors++; if (app_wdf_rdy !== 1'b1) begin miscompares++; $display("FAIL data_first_release got %0b want 1", app_wdf_rdy); end
        read_burst(27'h18, lat, d0, d1, v1);
        vectors++; if (lat != 8 || d0 !== PC || v1 !== 1'b1 || d1 !== PD) begin
            miscompares++; $display("FAIL data_first_read got lat=%0d b0=%h v1=%0b b1=%h want 8 %h 1 %h", lat, d0, v1, d1, PC, PD);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] b0, exp;
        for (int i = 0; i < 8; i++) begin
            b0 = {32{8'(i + 1)}};
            write_burst(27'h100 + 27'(8 * i), b0, ~b0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (app_rdy !== 1'b1) begin miscompares++; $display("FAIL stream_rdy%0d got %0b want 1", i, app_rdy); end
            app_en = 1'b1; dram_read = 1'b1; app_addr = 27'h100 + 27'(8 * i); cyc();
        end
        app_en = 1'b0;
        vectors++; if (app_rdy !== 1'b0) begin miscompares++; $display("FAIL stream_full got %0b want 0", app_rdy); end
        for (int k = 8; k < 24; k++) begin
            b0  = {32{8'((k - 8) / 2 + 1)}};
            exp = (k % 2 == 0) ? b0 : ~b0;
            vectors++; if (app_rd_data_valid !== 1'b1 || app_rd_data !== exp) begin
                miscompares++; $display("FAIL stream_beat%0d got v=%0b d=%h want 1 %h", k - 8, app_rd_data_valid, app_rd_data, exp);
            end
            if (k == 9) begin
                vectors++; if (app_rdy !== 1'b0) begin miscompares++; $display("FAIL stream_rdy_beat1 got %0b want 0", app_rdy); end
            end
            if (k == 10) begin
                vectors++; if (app_rdy !== 1'b1) begin miscompares++; $display("FAIL stream_rdy_rise got %0b want 1", app_rdy); end
            end
            cyc();
        end
        vectors++; if (app_rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL stream_end got %0b want 0", app_rd_data_valid); end
    endtask

    task automatic test_wrap();
        int lat; logic [W-1:0] d0, d1; logic v1;
        write_burst(27'h0, PE, PF);
        read_burst(27'h2000, lat, d0, d1, v1);
        vectors++; if (d0 !== PE || d1 !== PF || v1 !== 1'b1) begin
            miscompares++; $display("FAIL wrap_read got b0=%h b1=%h want %h %h", d0, d1, PE, PF);
        end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL wrap_error got %0b want 0", error); end
    endtask

    task automatic test_err_end();
        do_reset(); cyc();
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = PA;
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL err_end_before got %0b want 0", error); end
        cyc();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_end_set got %0b want 1", error); end
        repeat (5) cyc();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_end_sticky got %0b want 1", error); end
    endtask

    task automatic test_err_addr();
        do_reset(); cyc();
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL err_addr_before got %0b want 0", error); end
        app_en = 1'b1; dram_read = 1'b1; app_addr = 27'h13; cyc();
        app_en = 1'b0;
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL err_addr_set got %0b want 1", error); end
        repeat (12) cyc();
    endtask

    task automatic test_reset_mid_read();
        int lat, nv; logic [W-1:0] d0, d1; logic v1;
        do_reset(); cyc();
        write_burst(27'h20, PG, PH);
        app_en = 1'b1; dram_read = 1'b1; app_addr = 27'h20; cyc();
        app_en = 1'b0;
        repeat (3) cyc();
        reset = 1'b1; nv = 0;
        repeat (4) begin cyc(); nv += int'(app_rd_data_valid); end
        reset = 1'b0;
        vectors++; if (app_rdy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_rdy0 got %0b want 0", app_rdy); end
        cyc();
        vectors++; if (app_rdy !== 1'b1) begin miscompares++; $display("FAIL mid_reset_rdy1 got %0b want 1", app_rdy); end
        repeat (12) begin nv += int'(app_rd_data_valid); cyc(); end
        vectors++; if (nv != 0) begin miscompares++; $display("FAIL mid_reset_no_beats got %0d want 0", nv); end
        read_burst(27'h20, lat, d0, d1, v1);
        vectors++; if (d0 !== PG || d1 !== PH) begin miscompares++; $display("FAIL mid_reset_keep20 got %h %h want %h %h", d0, d1, PG, PH); end
        read_burst(27'h10, lat, d0, d1, v1);
        vectors++; if (d0 !== PA || d1 !== PB) begin miscompares++; $display("FAIL mid_reset_keep10 got %h %h want %h %h", d0, d1, PA, PB); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL mid_reset_error got %0b want 0", error); end
    endtask

    initial begin
        test_reset();
        test_cmd_first();
        test_data_first();
        test_streaming();
        test_wrap();
        test_err_end();
        test_err_addr();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
